// File: rtl/exp_match_pipe.sv
// Exponent matcher: per-lane product exponent, masked max, saturated alignment shift, running block max.
// Latency: 3 en-cycles from input acceptance to registered outputs.
// Backpressure: en=0 freezes every stage, valid bits included; in_valid/in_last ignored while frozen.
module exp_match_pipe #(
  parameter int A_EXP_WIDTH   = 5,
  parameter int W_EXP_WIDTH   = 2,
  parameter int ACC_EXP_WIDTH = 6,
  parameter int VEC_LENGTH    = 8,
  parameter int SHIFT_MAX     = 15,
  parameter int DELTA_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  input  logic [VEC_LENGTH*A_EXP_WIDTH-1:0]    a_exp,
  input  logic [VEC_LENGTH*W_EXP_WIDTH-1:0]    w_exp,
  input  logic [VEC_LENGTH-1:0]                a_sign,
  input  logic [VEC_LENGTH-1:0]                w_sign,
  input  logic [VEC_LENGTH-1:0]                a_zero,
  input  logic [VEC_LENGTH-1:0]                w_zero,
  output logic                                 out_valid,
  output logic                                 out_last,
  output logic [VEC_LENGTH-1:0]                y_sign,
  output logic [VEC_LENGTH-1:0]                y_zero,
  output logic [VEC_LENGTH*DELTA_WIDTH-1:0]    delta_exp,
  output logic [ACC_EXP_WIDTH-1:0]             max_exp,
  output logic                                 all_zero,
  output logic [ACC_EXP_WIDTH-1:0]             blk_max_exp
);

  localparam logic [DELTA_WIDTH-1:0] SHIFT_SAT = DELTA_WIDTH'(SHIFT_MAX);

  // S0 registers
  logic                              s0_valid, s0_last;
  logic [VEC_LENGTH*A_EXP_WIDTH-1:0] s0_a_exp;
  logic [VEC_LENGTH*W_EXP_WIDTH-1:0] s0_w_exp;
  logic [VEC_LENGTH-1:0]             s0_a_sign, s0_w_sign, s0_a_zero, s0_w_zero;

  // S1 registers
  logic                                        s1_valid, s1_last;
  logic [VEC_LENGTH-1:0][ACC_EXP_WIDTH-1:0]    s1_v;
  logic [VEC_LENGTH-1:0]                       s1_z, s1_s;

  // S1 next-state
  logic [VEC_LENGTH-1:0][ACC_EXP_WIDTH-1:0]    v_nxt;
  logic [VEC_LENGTH-1:0]                       z_nxt, s_nxt;

  // S2 next-state and running block max
  logic [ACC_EXP_WIDTH-1:0]          max_nxt, blk_nxt, r_blk;
  logic [VEC_LENGTH*DELTA_WIDTH-1:0] delta_nxt;

  // Stage 0: capture the beat as presented
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid  <= 1'b0;
      s0_last   <= 1'b0;
      s0_a_exp  <= '0;
      s0_w_exp  <= '0;
      s0_a_sign <= '0;
      s0_w_sign <= '0;
      s0_a_zero <= '0;
      s0_w_zero <= '0;
    end else if (en) begin
      s0_valid  <= in_valid;
      s0_last   <= in_last;
      s0_a_exp  <= a_exp;
      s0_w_exp  <= w_exp;
      s0_a_sign <= a_sign;
      s0_w_sign <= w_sign;
      s0_a_zero <= a_zero;
      s0_w_zero <= w_zero;
    end
  end

  // Per-lane product exponent, zero flag and sign (sign forced to 0 on zero lanes)
  always_comb begin
    v_nxt = '0;
    z_nxt = '0;
    s_nxt = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      v_nxt[i] = ACC_EXP_WIDTH'(s0_a_exp[i*A_EXP_WIDTH +: A_EXP_WIDTH])
               + ACC_EXP_WIDTH'(s0_w_exp[i*W_EXP_WIDTH +: W_EXP_WIDTH]);
      z_nxt[i] = s0_a_zero[i] | s0_w_zero[i];
      s_nxt[i] = (s0_a_sign[i] ^ s0_w_sign[i]) & ~z_nxt[i];
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_v     <= '0;
      s1_z     <= '0;
      s1_s     <= '0;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      s1_v     <= v_nxt;
      s1_z     <= z_nxt;
      s1_s     <= s_nxt;
    end
  end

  // Balanced max tree over masked exponents; node k has children 2k and 2k+1, leaves at VEC_LENGTH..
  always_comb begin : max_tree
    logic [ACC_EXP_WIDTH-1:0] node [2*VEC_LENGTH];
    for (int k = 0; k < 2*VEC_LENGTH; k++) node[k] = '0;
    for (int i = 0; i < VEC_LENGTH; i++) node[VEC_LENGTH+i] = s1_z[i] ? '0 : s1_v[i];
    for (int k = VEC_LENGTH-1; k >= 1; k--)
      node[k] = (node[2*k] > node[2*k+1]) ? node[2*k] : node[2*k+1];
    max_nxt = node[1];
  end

  // Alignment shift per lane, saturating; zero lanes get the full shift
  always_comb begin
    logic [ACC_EXP_WIDTH-1:0] diff;
    delta_nxt = '0;
    diff      = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      diff = max_nxt - s1_v[i];
      if (s1_z[i] || (32'(diff) > 32'(SHIFT_MAX)))
        delta_nxt[i*DELTA_WIDTH +: DELTA_WIDTH] = SHIFT_SAT;
      else
        delta_nxt[i*DELTA_WIDTH +: DELTA_WIDTH] = diff[DELTA_WIDTH-1:0];
    end
  end

  // Running max including the current beat
  always_comb blk_nxt = (r_blk > max_nxt) ? r_blk : max_nxt;

  // Stage 2: registered outputs; the block register only moves on valid beats
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      y_sign      <= '0;
      y_zero      <= '0;
      delta_exp   <= '0;
      max_exp     <= '0;
      all_zero    <= 1'b0;
      blk_max_exp <= '0;
      r_blk       <= '0;
    end else if (en) begin
      out_valid   <= s1_valid;
      out_last    <= s1_last;
      y_sign      <= s1_s;
      y_zero      <= s1_z;
      delta_exp   <= delta_nxt;
      max_exp     <= max_nxt;
      all_zero    <= &s1_z;
      blk_max_exp <= blk_nxt;
      if (s1_valid) r_blk <= s1_last ? '0 : blk_nxt;
    end
  end

endmodule

// File: tb/tb_exp_match_pipe.sv
// Directed + light random bench for exp_match_pipe with a queue scoreboard.
// Expected beats are pushed when accepted and popped when a fresh output beat appears.
// Stall handling: the monitor only pops after an advancing (en=1, no reset) edge.
module tb_exp_match_pipe;
  localparam int V  = 8;
  localparam int AW = 5;
  localparam int WW = 2;
  localparam int XW = 6;
  localparam int DW = 4;
  localparam int SM = 15;

  logic clk = 1'b0;
  logic reset, en, in_valid, in_last;
  logic [V*AW-1:0] a_exp;
  logic [V*WW-1:0] w_exp;
  logic [V-1:0]    a_sign, w_sign, a_zero, w_zero;
  logic            out_valid, out_last, all_zero;
  logic [V-1:0]    y_sign, y_zero;
  logic [V*DW-1:0] delta_exp;
  logic [XW-1:0]   max_exp, blk_max_exp;

  typedef struct packed {
    logic [V-1:0]    sgn;
    logic [V-1:0]    zro;
    logic [V*DW-1:0] dlt;
    logic [XW-1:0]   mx;
    logic            az;
    logic [XW-1:0]   blk;
    logic            lst;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   tb_r   = 0;
  logic adv    = 1'b0;
  int   a_arr[V];
  int   w_arr[V];

  exp_match_pipe #(
    .A_EXP_WIDTH(AW), .W_EXP_WIDTH(WW), .ACC_EXP_WIDTH(XW),
    .VEC_LENGTH(V), .SHIFT_MAX(SM), .DELTA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_last(in_last),
    .a_exp(a_exp), .w_exp(w_exp), .a_sign(a_sign), .w_sign(w_sign),
    .a_zero(a_zero), .w_zero(w_zero),
    .out_valid(out_valid), .out_last(out_last), .y_sign(y_sign), .y_zero(y_zero),
    .delta_exp(delta_exp), .max_exp(max_exp), .all_zero(all_zero), .blk_max_exp(blk_max_exp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat for one clock edge, modelling the expected output if it will be accepted.
  task automatic beat(input int a[V], input int w[V], input logic [V-1:0] az, input logic [V-1:0] wz,
                      input logic [V-1:0] as, input logic [V-1:0] ws, input logic lst);
    exp_t e;
    int   v[V];
    logic z[V];
    int   mx, d, bm;
    mx = 0;
    e  = '0;
    for (int i = 0; i < V; i++) begin
      a_exp[i*AW +: AW] = AW'(a[i]);
      w_exp[i*WW +: WW] = WW'(w[i]);
      v[i] = a[i] + w[i];
      z[i] = az[i] | wz[i];
      e.zro[i] = z[i];
      e.sgn[i] = (as[i] ^ ws[i]) & ~z[i];
      if (!z[i] && v[i] > mx) mx = v[i];
    end
    for (int i = 0; i < V; i++) begin
      d = z[i] ? SM : ((mx - v[i] > SM) ? SM : mx - v[i]);
      e.dlt[i*DW +: DW] = DW'(d);
    end
    e.mx  = XW'(mx);
    e.az  = &e.zro;
    e.lst = lst;
    a_zero = az; w_zero = wz; a_sign = as; w_sign = ws;
    in_valid = 1'b1;
    in_last  = lst;
    if (en && !reset) begin
      bm    = (tb_r > mx) ? tb_r : mx;
      e.blk = XW'(bm);
      tb_r  = lst ? 0 : bm;
      q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Simple beat: lane 0 carries the maximum, other lanes are small
  task automatic beat_max(input int m, input logic lst);
    for (int i = 0; i < V; i++) begin a_arr[i] = i % 2; w_arr[i] = 0; end
    a_arr[0] = m - 2;
    w_arr[0] = 2;
    beat(a_arr, w_arr, 8'h00, 8'h00, 8'h5A, 8'h0F, lst);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  always @(posedge clk) adv <= en && !reset;

  always @(negedge clk) begin
    if (adv && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 64'(out_valid), 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("sb_sign",     64'(y_sign),      64'(mon_e.sgn));
        chk("sb_zero",     64'(y_zero),      64'(mon_e.zro));
        chk("sb_delta",    64'(delta_exp),   64'(mon_e.dlt));
        chk("sb_max",      64'(max_exp),     64'(mon_e.mx));
        chk("sb_all_zero", 64'(all_zero),    64'(mon_e.az));
        chk("sb_blk_max",  64'(blk_max_exp), 64'(mon_e.blk));
        chk("sb_last",     64'(out_last),    64'(mon_e.lst));
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    a_exp = '0; w_exp = '0; a_sign = '0; w_sign = '0; a_zero = '0; w_zero = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_max",       64'(max_exp),     64'd0);
    chk("rst_blk",       64'(blk_max_exp), 64'd0);
    chk("rst_delta",     64'(delta_exp),   64'd0);
    chk("rst_all_zero",  64'(all_zero),    64'd0);

    // All lanes non-zero: max 33 from lane 5, everything else saturates
    a_arr = '{3, 7, 10, 1, 0, 31, 5, 9};
    w_arr = '{2, 2, 2, 2, 2, 2, 2, 2};
    beat(a_arr, w_arr, 8'h00, 8'h00, 8'b1010_0110, 8'b0110_0011, 1'b1);
    tick();
    chk("lat_edge2_invalid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_edge3_valid", 64'(out_valid), 64'd1);
    chk("s1_max",   64'(max_exp),     64'd33);
    chk("s1_delta", 64'(delta_exp),   64'h0000_0000_FF0F_FFFF);
    chk("s1_blk",   64'(blk_max_exp), 64'd33);
    drain();

    // Lane 5 masked out by a_zero
    beat(a_arr, w_arr, 8'h20, 8'h00, 8'hFF, 8'h00, 1'b1);
    repeat (2) tick();
    chk("s2_max",    64'(max_exp),   64'd12);
    chk("s2_delta",  64'(delta_exp), 64'h0000_0000_15FA_9037);
    chk("s2_yzero5", 64'(y_zero[5]), 64'd1);
    chk("s2_ysign5", 64'(y_sign[5]), 64'd0);
    drain();

    // Every weight zero
    beat(a_arr, w_arr, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1);
    repeat (2) tick();
    chk("s3_all_zero", 64'(all_zero),  64'd1);
    chk("s3_max",      64'(max_exp),   64'd0);
    chk("s3_delta",    64'(delta_exp), 64'h0000_0000_FFFF_FFFF);
    chk("s3_sign",     64'(y_sign),    64'd0);
    drain();

    // Three-beat block then a single-beat block, back to back
    beat_max(20, 1'b0);
    beat_max(25, 1'b0);
    beat_max(18, 1'b1);
    beat_max(4,  1'b1);
    drain();

    // Stall with three beats in flight; garbage presented during the stall must be ignored
    beat_max(10, 1'b0);
    beat_max(11, 1'b0);
    beat_max(12, 1'b1);
    en = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b1;
    tick();
    chk("stall1_valid", 64'(out_valid), 64'd1);
    chk("stall1_max",   64'(max_exp),   64'd10);
    tick();
    chk("stall2_valid", 64'(out_valid), 64'd1);
    chk("stall2_max",   64'(max_exp),   64'd10);
    in_valid = 1'b0;
    in_last  = 1'b0;
    en = 1'b1;
    drain();

    // Reset mid-block, then a fresh single-beat block
    beat_max(30, 1'b0);
    beat_max(28, 1'b0);
    drain();
    reset = 1'b1;
    tick();
    chk("rst_mid_valid1", 64'(out_valid), 64'd0);
    tick();
    chk("rst_mid_valid2", 64'(out_valid),   64'd0);
    chk("rst_mid_blk",    64'(blk_max_exp), 64'd0);
    reset = 1'b0;
    tb_r  = 0;
    beat_max(6, 1'b1);
    repeat (2) tick();
    chk("post_rst_blk", 64'(blk_max_exp), 64'd6);
    drain();

    // Random beats with occasional bubbles and zero lanes
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < V; i++) begin
        a_arr[i] = $urandom_range(31, 0);
        w_arr[i] = $urandom_range(3, 0);
      end
      beat(a_arr, w_arr, V'($urandom & $urandom), V'($urandom & $urandom & $urandom),
           V'($urandom), V'($urandom), 1'($urandom_range(3, 0) == 0));
      if ($urandom_range(3, 0) == 0) tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
